prf_bypass_scoreboard: RTL



---
 rtl/common_pkg.sv | 10 +
 rtl/prf_ready_table.sv | 56 +++++
 rtl/prf_bypass_scoreboard.sv | 72 +++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types and constants for the physical register file slice.
package common;
  localparam int unsigned PREG_NUM    = 64;
  localparam int unsigned PREG_ADDR_W = $clog2(PREG_NUM);

  typedef logic [PREG_ADDR_W-1:0] preg_addr_t;
  typedef logic [63:0]            u64;

  localparam preg_addr_t PREG_ZERO = '0;
endpackage

// File: rtl/prf_ready_table.sv
// Per-register ready scoreboard: cleared on allocation, set on writeback,
// bulk-set on flush; combinational lookup per read port with write forwarding.
module prf_ready_table
  import common::*;
#(
  parameter int unsigned NUM_PREG    = PREG_NUM,
  parameter int unsigned ADDR_W      = $clog2(NUM_PREG),
  parameter int unsigned READ_PORTS  = 8,
  parameter int unsigned WRITE_PORTS = 2,
  parameter int unsigned ALLOC_PORTS = 2,
  parameter bit          BYPASS      = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [READ_PORTS-1:0][ADDR_W-1:0]     ra,
  output logic [READ_PORTS-1:0]                 rrdy,
  input  logic [WRITE_PORTS-1:0]                wvalid,
  input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]    wa,
  input  logic [ALLOC_PORTS-1:0]                avalid,
  input  logic [ALLOC_PORTS-1:0][ADDR_W-1:0]    aa,
  input  logic                                  flush
);

  logic [NUM_PREG-1:0] rdy_q;
  logic [NUM_PREG-1:0] rdy_d;
  logic [NUM_PREG-1:0] wr_hit;
  logic [NUM_PREG-1:0] al_hit;

  // Priority: flush over allocation over writeback; register 0 stays ready.
  always_comb begin
    wr_hit = '0;
    al_hit = '0;
    for (int j = 0; j < int'(WRITE_PORTS); j++)
      if (wvalid[j]) wr_hit[wa[j]] = 1'b1;
    for (int k = 0; k < int'(ALLOC_PORTS); k++)
      if (avalid[k]) al_hit[aa[k]] = 1'b1;
    rdy_d = (rdy_q | wr_hit) & ~al_hit;
    if (flush) rdy_d = '1;
    rdy_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_q <= '1;
    else        rdy_q <= rdy_d;
  end

  always_comb begin
    rrdy = '0;
    for (int i = 0; i < int'(READ_PORTS); i++) begin
      rrdy[i] = rdy_q[ra[i]];
      if (ra[i] == ADDR_W'(PREG_ZERO))    rrdy[i] = 1'b1;
      else if (BYPASS && wr_hit[ra[i]])   rrdy[i] = 1'b1;
    end
  end

endmodule

// File: rtl/prf_bypass_scoreboard.sv
// Multi-ported physical register file with optional write-to-read bypass
// and an attached ready scoreboard.
module prf_bypass_scoreboard
  import common::*;
#(
  parameter int unsigned NUM_PREG    = PREG_NUM,
  parameter int unsigned ADDR_W      = $clog2(NUM_PREG),
  parameter int unsigned DATA_W      = $bits(u64),
  parameter int unsigned READ_PORTS  = 8,
  parameter int unsigned WRITE_PORTS = 2,
  parameter int unsigned ALLOC_PORTS = 2,
  parameter bit          BYPASS      = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [READ_PORTS-1:0][ADDR_W-1:0]     ra,
  output logic [READ_PORTS-1:0][DATA_W-1:0]     rd,
  output logic [READ_PORTS-1:0]                 rrdy,
  input  logic [WRITE_PORTS-1:0]                wvalid,
  input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]    wa,
  input  logic [WRITE_PORTS-1:0][DATA_W-1:0]    wd,
  input  logic [ALLOC_PORTS-1:0]                avalid,
  input  logic [ALLOC_PORTS-1:0][ADDR_W-1:0]    aa,
  input  logic                                  flush
);

  logic [DATA_W-1:0] data_q [NUM_PREG];

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < int'(NUM_PREG); r++) data_q[r] <= '0;
    end else begin
      for (int j = 0; j < int'(WRITE_PORTS); j++)
        if (wvalid[j] && wa[j] != ADDR_W'(PREG_ZERO)) data_q[wa[j]] <= wd[j];
    end
  end

  // Forwarding is suppressed in reset so readers see the cleared array.
  always_comb begin
    rd = '0;
    for (int i = 0; i < int'(READ_PORTS); i++) begin
      if (ra[i] != ADDR_W'(PREG_ZERO)) begin
        rd[i] = data_q[ra[i]];
        if (BYPASS && reset) begin
          for (int j = 0; j < int'(WRITE_PORTS); j++)
            if (wvalid[j] && wa[j] == ra[i]) rd[i] = wd[j];
        end
      end
    end
  end

  prf_ready_table #(
    .NUM_PREG    (NUM_PREG),
    .ADDR_W      (ADDR_W),
    .READ_PORTS  (READ_PORTS),
    .WRITE_PORTS (WRITE_PORTS),
    .ALLOC_PORTS (ALLOC_PORTS),
    .BYPASS      (BYPASS)
  ) u_ready (
    .clk    (clk),
    .reset  (reset),
    .ra     (ra),
    .rrdy   (rrdy),
    .wvalid (wvalid),
    .wa     (wa),
    .avalid (avalid),
    .aa     (aa),
    .flush  (flush)
  );

endmodule
